lvds_word_aligner: RTL



---
 rtl/lvds_align_pkg.sv | 26 ++
 rtl/lvds_align_ch.sv | 136 +++++++++++++
 rtl/lvds_word_aligner.sv | 52 +++++
 3 files changed

// File: rtl/lvds_align_pkg.sv
// Shared types and constants for the LVDS word aligner: per-channel FSM states,
// default comma words and the comma comparator.
package lvds_align_pkg;

    // Widest word the comma comparator accepts; narrower words are zero-extended.
    localparam int unsigned WORD_MAX = 64;

    localparam logic [9:0] COMMA_P_DEF = 10'b01_0111_1100;
    localparam logic [9:0] COMMA_N_DEF = 10'b10_1000_0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED,
        ST_FAIL
    } align_state_e;

    function automatic logic is_comma(input logic [WORD_MAX-1:0] word,
                                      input logic [WORD_MAX-1:0] comma_p,
                                      input logic [WORD_MAX-1:0] comma_n);
        return (word == comma_p) || (word == comma_n);
    endfunction

endpackage

// File: rtl/lvds_align_ch.sv
// One channel of the word aligner: bitslip search FSM with settle, hit and slip counters.
// Loss-of-alignment realign is compiled in when LVDS_ALIGN_LOSS_EN is defined.
module lvds_align_ch
    import lvds_align_pkg::*;
#(
    parameter int unsigned       DATA_W    = 10,
    parameter logic [DATA_W-1:0] COMMA_P   = DATA_W'(COMMA_P_DEF),
    parameter logic [DATA_W-1:0] COMMA_N   = DATA_W'(COMMA_N_DEF),
    parameter int unsigned       SLIP_WAIT = 16,
    parameter int unsigned       HITS      = 3,
    parameter int unsigned       MAX_SLIPS = DATA_W,
    parameter int unsigned       LOSS_THR  = 4
) (
    input  logic              rx_clk,
    input  logic              rx_rst,
    input  logic              rx_locked,
    input  logic              train_en,
    input  logic [DATA_W-1:0] data,
    output logic              slip_pulse,
    output logic              done,
    output logic              fail
);

    localparam int unsigned SLIP_CW = $clog2(MAX_SLIPS + 1);
    localparam int unsigned WAIT_CW = $clog2(SLIP_WAIT + 1);
    localparam int unsigned HIT_CW  = $clog2(HITS + 1);

    align_state_e       state, state_nxt;
    logic [SLIP_CW-1:0] slip_cnt, slip_cnt_nxt;
    logic [WAIT_CW-1:0] wait_cnt, wait_cnt_nxt;
    logic [HIT_CW-1:0]  hit_cnt, hit_cnt_nxt;
    logic               comma;

`ifdef LVDS_ALIGN_LOSS_EN
    localparam int unsigned LOSS_CW = $clog2(LOSS_THR + 1);
    logic [LOSS_CW-1:0] loss_cnt, loss_cnt_nxt;
`endif

    assign comma = is_comma(WORD_MAX'(data), WORD_MAX'(COMMA_P), WORD_MAX'(COMMA_N));

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        slip_cnt_nxt = slip_cnt;
        wait_cnt_nxt = wait_cnt;
        hit_cnt_nxt  = hit_cnt;
`ifdef LVDS_ALIGN_LOSS_EN
        loss_cnt_nxt = '0;
`endif
        if (!rx_locked) begin
            state_nxt    = ST_IDLE;
            slip_cnt_nxt = '0;
            wait_cnt_nxt = '0;
            hit_cnt_nxt  = '0;
        end else if (!train_en &&
                     (state == ST_WAIT || state == ST_CHECK || state == ST_SLIP)) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    slip_cnt_nxt = '0;
                    wait_cnt_nxt = '0;
                    hit_cnt_nxt  = '0;
                    if (train_en) state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    hit_cnt_nxt = '0;
                    if (wait_cnt == WAIT_CW'(SLIP_WAIT - 1)) begin
                        wait_cnt_nxt = '0;
                        state_nxt    = ST_CHECK;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (comma) begin
                        if (hit_cnt == HIT_CW'(HITS - 1)) state_nxt = ST_LOCKED;
                        else hit_cnt_nxt = hit_cnt + 1'b1;
                    end else begin
                        hit_cnt_nxt = '0;
                        state_nxt   = (slip_cnt < SLIP_CW'(MAX_SLIPS)) ? ST_SLIP : ST_FAIL;
                    end
                end
                ST_SLIP: begin
                    if (slip_cnt != SLIP_CW'(MAX_SLIPS)) slip_cnt_nxt = slip_cnt + 1'b1;
                    wait_cnt_nxt = '0;
                    state_nxt    = ST_WAIT;
                end
                ST_LOCKED: begin
`ifdef LVDS_ALIGN_LOSS_EN
                    // Only a run of misses during training counts as lost alignment.
                    if (train_en && !comma) begin
                        if (loss_cnt == LOSS_CW'(LOSS_THR - 1)) begin
                            slip_cnt_nxt = '0;
                            state_nxt    = ST_SLIP;
                        end else begin
                            loss_cnt_nxt = loss_cnt + 1'b1;
                        end
                    end
`endif
                end
                ST_FAIL: ;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: state and counters use non-blocking assignments so all flops update together.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state      <= ST_IDLE;
            slip_cnt   <= '0;
            wait_cnt   <= '0;
            hit_cnt    <= '0;
`ifdef LVDS_ALIGN_LOSS_EN
            loss_cnt   <= '0;
`endif
            slip_pulse <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_nxt;
            slip_cnt   <= slip_cnt_nxt;
            wait_cnt   <= wait_cnt_nxt;
            hit_cnt    <= hit_cnt_nxt;
`ifdef LVDS_ALIGN_LOSS_EN
            loss_cnt   <= loss_cnt_nxt;
`endif
            // Flags follow the state one cycle later and drop as soon as it is left.
            slip_pulse <= (state_nxt == ST_SLIP);
            done       <= (state == ST_LOCKED) && (state_nxt == ST_LOCKED);
            fail       <= (state == ST_FAIL) && (state_nxt == ST_FAIL);
        end
    end

endmodule

// File: rtl/lvds_word_aligner.sv
// Multi-channel LVDS word aligner top: slices rx_data per channel and registers all_aligned.
// Define LVDS_ALIGN_LOSS_EN to make locked channels realign after LOSS_THR missed commas.
module lvds_word_aligner
    import lvds_align_pkg::*;
#(
    parameter int unsigned       DATA_W    = 10,
    parameter int unsigned       CH        = 4,
    parameter logic [DATA_W-1:0] COMMA_P   = DATA_W'(COMMA_P_DEF),
    parameter logic [DATA_W-1:0] COMMA_N   = DATA_W'(COMMA_N_DEF),
    parameter int unsigned       SLIP_WAIT = 16,
    parameter int unsigned       HITS      = 3,
    parameter int unsigned       MAX_SLIPS = DATA_W,
    parameter int unsigned       LOSS_THR  = 4
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst,
    input  logic                 rx_locked,
    input  logic [CH*DATA_W-1:0] rx_data,
    input  logic                 train_en,
    output logic [CH-1:0]        rx_data_align,
    output logic [CH-1:0]        align_done,
    output logic [CH-1:0]        align_fail,
    output logic                 all_aligned
);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        lvds_align_ch #(
            .DATA_W   (DATA_W),
            .COMMA_P  (COMMA_P),
            .COMMA_N  (COMMA_N),
            .SLIP_WAIT(SLIP_WAIT),
            .HITS     (HITS),
            .MAX_SLIPS(MAX_SLIPS),
            .LOSS_THR (LOSS_THR)
        ) u_ch (
            .rx_clk    (rx_clk),
            .rx_rst    (rx_rst),
            .rx_locked (rx_locked),
            .train_en  (train_en),
            .data      (rx_data[c*DATA_W +: DATA_W]),
            .slip_pulse(rx_data_align[c]),
            .done      (align_done[c]),
            .fail      (align_fail[c])
        );
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst || !rx_locked) all_aligned <= 1'b0;
        else                      all_aligned <= &align_done;
    end

endmodule
